// File: rtl/systolic_collector.sv
// Collects finished results from the end of a systolic chain into a FWFT circular buffer, tagging frame ends.
// Latency: a word captured on edge k is visible on out_data in the following cycle.
// Backpressure: none toward the array; a capture into a full buffer without a same-cycle pop is dropped and flagged in ovf.
module systolic_collector #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         x_in,
    input  logic                     s_in,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] dat;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [FW-1:0]   frm_q, frm_d;
    logic            ovf_q, ovf_d;

    logic pop, full, accept, drop, frm_end;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        frm_d    = frm_q;

        // Pop only what is already visible, so a capture into an empty buffer never pops itself.
        pop     = (level_q != '0) && out_ready;
        full    = (level_q == LW'(DEPTH));
        accept  = s_in && (!full || pop);
        drop    = s_in && full && !pop;
        frm_end = (frm_q == FW'(FRAME_LEN - 1));

        if (accept) begin
            mem_d[wr_ptr_q] = '{last: frm_end, dat: x_in};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Frame position tracks every capture event, including dropped ones.
        if (s_in) begin
            frm_d = frm_end ? '0 : frm_q + 1'b1;
        end

        case ({accept, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        ovf_d = drop | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            frm_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            frm_q    <= frm_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q].dat  : '0;
    assign out_last  = out_valid ? mem_q[rd_ptr_q].last : 1'b0;
    assign level     = level_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_systolic_collector.sv
// Bench for systolic_collector: a cycle model keeps the expected buffer as a queue,
// pushed when a capture is driven and popped when the consumer takes the head word.
module tb_systolic_collector;
    localparam int WIDTH     = 32;
    localparam int DEPTH     = 8;
    localparam int FRAME_LEN = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] x_in = '0;
    logic             s_in = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       level;
    logic             ovf;
    logic             ovf_clr = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    logic [WIDTH:0] mq[$];
    int             mfrm = 0;
    bit             movf = 1'b0;

    systolic_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_in),
        .s_in      (s_in),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, compare visible outputs with the model, then advance the model.
    task automatic step(input bit s, input logic [WIDTH-1:0] x, input bit rdy, input bit clr);
        bit pop, full, accept;
        logic [WIDTH:0] head;
        @(negedge clk);
        s_in      = s;
        x_in      = x;
        out_ready = rdy;
        ovf_clr   = clr;
        #1;
        check("level", 64'(level), 64'(mq.size()));
        check("valid", 64'(out_valid), 64'(mq.size() != 0));
        check("ovf", 64'(ovf), 64'(movf));
        if (mq.size() != 0) begin
            head = mq[0];
            check("data", 64'(out_data), 64'(head[WIDTH-1:0]));
            check("last", 64'(out_last), 64'(head[WIDTH]));
        end
        pop    = (mq.size() != 0) && rdy;
        full   = (mq.size() == DEPTH);
        accept = s && (!full || pop);
        if (pop) void'(mq.pop_front());
        if (clr) movf = 1'b0;
        if (s) begin
            if (accept) mq.push_back({(mfrm == FRAME_LEN - 1), x});
            else        movf = 1'b1;
            mfrm = (mfrm + 1) % FRAME_LEN;
        end
    endtask

    // Asynchronous reset pulse with s_in asserted across the reset edge, which must be ignored.
    task automatic rst_pulse();
        @(negedge clk);
        s_in      = 1'b1;
        x_in      = 32'd77;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        rst       = 1'b0;
        #1;
        check("rst_level", 64'(level), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        mq.delete();
        mfrm = 0;
        movf = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        s_in = 1'b0;
    endtask

    initial begin
        bit s;
        rst_pulse();

        // Streaming with consumer always ready.
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(10 * i), 1'b1, 1'b0);
        repeat (2) step(1'b0, 32'hdead, 1'b1, 1'b0);

        // Overfill: 9 and 10 dropped; clear coincides with the second drop, then clear alone.
        for (int i = 1; i <= 9; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'd10, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        repeat (9) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Full buffer with simultaneous capture and pop.
        rst_pulse();
        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'd99, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        repeat (9) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Reset in the middle of a partial frame.
        for (int i = 1; i <= 2; i++) step(1'b1, 32'(50 + i), 1'b0, 1'b0);
        rst_pulse();
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(60 + i), 1'b1, 1'b0);
        repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Random traffic: toggling captures, sparse then plentiful readiness.
        s = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step(s, $urandom, (i < 100) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 15) == 0));
            s = ~s;
        end
        repeat (12) step(1'b0, 32'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
